alu_seq_mul: RTL and testbench
==============================

Name: alu_seq_mul

Overview:
- Execute-stage ALU, directly downstream of the ALU decoder; consumes the 3-bit ALUControl code and the two operands.
- add, sub, slt, and, or resolve combinationally in the issue cycle.
- mul runs on an iterative radix-2 shift-add multiplier and raises Stall so the core freezes PC and register writeback until the product is ready.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- Valid  in  1  an instruction is present in execute this cycle.
- ALUControl  in  3  010 add, 100 sub, 110 slt, 101 mul, 000 and, 001 or; any other code performs add.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B.
- ALUResult  out  WIDTH  result.
- Zero  out  1  high when ALUResult equals 0.
- Stall  out  1  freeze PC and writeback.
- MulDone  out  1  one-cycle pulse; product valid on ALUResult.

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE, clears the product, multiplicand, multiplier and counter registers; Stall=0, MulDone=0.
- IDLE, non-mul op:
  - ALUResult computed combinationally; Stall=0.
  - sub is A-B mod 2^WIDTH.
  - slt is a signed compare, result zero-extended 1 or 0.
  - Overflow ignored for all ops.
- IDLE, Valid=1 and ALUControl=101 (launch):
  - Stall=1 combinationally; ALUResult=0.
  - Latch multiplicand=SrcA, multiplier=SrcB, product=0, count=0; go to BUSY.
- BUSY, each cycle:
  - If multiplier[0]=1, add multiplicand to product.
  - Shift multiplicand left 1 and multiplier right 1; increment count.
  - Stall=1, ALUResult=0, MulDone=0.
  - Go to DONE at the end of the cycle where count = WIDTH-1.
- DONE:
  - ALUResult = product[WIDTH-1:0] (low word; identical for signed and unsigned operands).
  - MulDone=1, Stall=0, so the same mul instruction retires this cycle.
  - Always return to IDLE; no launch is taken from DONE.
- Latency (base build): launch cycle t; Stall high for cycles t..t+WIDTH; MulDone at t+WIDTH+1.
- Zero follows ALUResult in every state, so it is 1 during BUSY.
- Valid and operand changes during BUSY or DONE are ignored.
- Back-to-back mul: second launch occurs in the IDLE cycle after DONE.
- Reset during BUSY or DONE: immediate IDLE; partial product discarded; no MulDone pulse.

Optional Feature:
- Macro ALU_EARLY_TERM_EN.
- Defined: BUSY also exits to DONE at the end of any cycle whose post-shift multiplier is 0.
  - Minimum one BUSY cycle.
  - mul by 0 or 1: Stall high 2 cycles, MulDone at t+2.
- Undefined: fixed WIDTH BUSY cycles regardless of operand values.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code localparams ALU_ADD=010, ALU_SUB=100, ALU_SLT=110, ALU_MUL=101, ALU_AND=000, ALU_OR=001, shared with the decoder.
  - State encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
- One sub-module, seq_multiplier: owns the datapath registers, counter and early-termination logic; exposes start, busy, done, product.
- Top level keeps the combinational ops, output muxing and Stall generation.

Test Plan:
- add 5+7 -> ALUResult=12, Zero=0, Stall=0 in the same cycle; sub 7-7 -> 0, Zero=1.
- slt SrcA=0xFFFFFFFF, SrcB=1 -> 1; swapped operands -> 0; code 111 -> add result.
- mul 6*7 launched at t -> Stall high t..t+32, MulDone and ALUResult=42 at t+33, Stall=0 at t+33.
- mul 0xFFFFFFFF*2 -> 0xFFFFFFFE; then immediate second mul 3*3 -> launches at t+34, result 9 at t+67.
- Assert rst at BUSY cycle 10 -> Stall=0 and IDLE at once, no MulDone; relaunch 4*5 -> 20 with full latency.
- With ALU_EARLY_TERM_EN: 3*1 -> MulDone at t+2, result 3; 3*0x80000000 -> full 32-cycle latency, result 0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the decoder and the execute
// stage, plus the state encoding of the iterative multiplier.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/alu_seq_mul_if.sv
// Execute-stage ALU bundle: instruction/operands in, result and pipeline
// control (Stall, MulDone) out.
interface alu_seq_mul_if #(
  parameter int WIDTH = 32
);

  logic             Valid;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Stall;
  logic             MulDone;

  modport master (
    output Valid, ALUControl, SrcA, SrcB,
    input  ALUResult, Zero, Stall, MulDone
  );

  modport slave (
    input  Valid, ALUControl, SrcA, SrcB,
    output ALUResult, Zero, Stall, MulDone
  );

endinterface

// File: rtl/alu_seq_mul_seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low WIDTH bits of the product.
// Define ALU_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  mul_state_t       state;
  mul_state_t       state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mplier_shift;
  logic             last_iter;

  assign mplier_shift = {1'b0, mplier[WIDTH-1:1]};

`ifdef ALU_EARLY_TERM_EN
  // Leave after this cycle if every remaining multiplier bit is already zero.
  assign last_iter = (count == CNT_W'(WIDTH - 1)) || (mplier_shift == {WIDTH{1'b0}});
`else
  assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always falls back to IDLE so no launch is taken there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_nxt = DONE;
        end else begin
          state_nxt = BUSY;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on launch, one shift-add step per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= {WIDTH{1'b0}};
      mplier <= {WIDTH{1'b0}};
      prod   <= {WIDTH{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= multiplicand_in;
            mplier <= multiplier_in;
            prod   <= {WIDTH{1'b0}};
            count  <= {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= mplier_shift;
          count  <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          mcand  <= mcand;
          mplier <= mplier;
          prod   <= prod;
          count  <= count;
        end
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign done    = (state == DONE);
  assign product = prod;

endmodule

// File: rtl/alu_seq_mul.sv
// Execute-stage ALU: single-cycle add/sub/slt/and/or, multi-cycle mul with Stall.
// Optional macro ALU_EARLY_TERM_EN enables early exit of the multiplier.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_mul_if.slave bus
);

  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] result;

  // Launch only from IDLE; operand and Valid changes while busy/done are ignored.
  assign start = bus.Valid && (bus.ALUControl == ALU_MUL) && !busy && !done;

  seq_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .multiplicand_in (bus.SrcA),
    .multiplier_in   (bus.SrcB),
    .busy            (busy),
    .done            (done),
    .product         (product)
  );

  // Single-cycle operations; unlisted codes behave as add.
  always_comb begin
    comb_result = {WIDTH{1'b0}};
    case (bus.ALUControl)
      ALU_ADD: comb_result = bus.SrcA + bus.SrcB;
      ALU_SUB: comb_result = bus.SrcA - bus.SrcB;
      ALU_SLT: begin
        if ($signed(bus.SrcA) < $signed(bus.SrcB)) begin
          comb_result = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          comb_result = {WIDTH{1'b0}};
        end
      end
      ALU_AND: comb_result = bus.SrcA & bus.SrcB;
      ALU_OR:  comb_result = bus.SrcA | bus.SrcB;
      ALU_MUL: comb_result = {WIDTH{1'b0}};
      default: comb_result = bus.SrcA + bus.SrcB;
    endcase
  end

  // Output selection: product in DONE, zero while a multiply is in flight.
  always_comb begin
    result = {WIDTH{1'b0}};
    if (done) begin
      result = product;
    end else if (busy || start) begin
      result = {WIDTH{1'b0}};
    end else begin
      result = comb_result;
    end
  end

  assign bus.ALUResult = result;
  assign bus.Zero      = (result == {WIDTH{1'b0}});
  assign bus.Stall     = start || busy;
  assign bus.MulDone   = done;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Self-checking bench for alu_seq_mul: vector table, random single-cycle ops
// and multiply sequences checked against an arithmetic reference model.
module tb_alu_seq_mul;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_seq_mul_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_mul #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000:  return a & b;
      3'b001:  return a | b;
      default: return a + b;
    endcase
  endfunction

  // Cycles from launch to MulDone.
  function automatic int exp_latency(input logic [31:0] b);
`ifdef ALU_EARLY_TERM_EN
    int n;
    n = 0;
    while (n < WIDTH && (b >> n) != 32'd0) n++;
    if (n == 0) n = 1;
    return n + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic apply_comb(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
    @(negedge clk);
    bus.Valid = 1'b1; bus.ALUControl = c; bus.SrcA = a; bus.SrcB = b;
    #2;
    check("comb_result", bus.ALUResult, exp);
    check("comb_zero", bus.Zero, (exp == 32'd0));
    check("comb_stall", bus.Stall, 1'b0);
  endtask

  // Launch a multiply, scramble inputs while it runs, then check timing and product.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit seen;
    logic [31:0] exp;
    lat  = exp_latency(b);
    exp  = a * b;
    seen = 1'b0;
    @(negedge clk);
    bus.Valid = 1'b1; bus.ALUControl = ALU_MUL; bus.SrcA = a; bus.SrcB = b;
    #2;
    check("launch_stall", bus.Stall, 1'b1);
    check("launch_result", bus.ALUResult, 32'd0);
    for (int c = 1; c <= WIDTH + 4 && !seen; c++) begin
      @(negedge clk);
      bus.Valid = 1'($urandom_range(0, 1));
      bus.ALUControl = ALU_MUL;
      bus.SrcA = $urandom;
      bus.SrcB = $urandom;
      #2;
      if (bus.MulDone) begin
        seen = 1'b1;
        check("mul_latency", c, lat);
        check("mul_result", bus.ALUResult, exp);
        check("done_stall", bus.Stall, 1'b0);
        check("done_zero", bus.Zero, (exp == 32'd0));
      end else begin
        check("busy_stall", bus.Stall, 1'b1);
        check("busy_zero", bus.Zero, 1'b1);
      end
    end
    if (!seen) check("mul_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{3'b010, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{3'b100, 32'd7,          32'd7,          32'd0};
    vecs[2] = '{3'b110, 32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[3] = '{3'b110, 32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[4] = '{3'b111, 32'd3,          32'd4,          32'd7};
    vecs[5] = '{3'b000, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234};
    vecs[6] = '{3'b001, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    vecs[7] = '{3'b100, 32'd3,          32'd5,          32'hFFFF_FFFE};
    vecs[8] = '{3'b110, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
    vecs[9] = '{3'b011, 32'hFFFF_FFFF,  32'd1,          32'd0};

    rst = 1'b1;
    bus.Valid = 1'b0; bus.ALUControl = ALU_ADD; bus.SrcA = 32'd0; bus.SrcB = 32'd0;
    #2;
    check("reset_stall", bus.Stall, 1'b0);
    check("reset_muldone", bus.MulDone, 1'b0);
    check("reset_zero", bus.Zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_comb(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      if (c == ALU_MUL) c = 3'b111;
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      apply_comb(c, a, b, ref_alu(c, a, b));
    end

    do_mul(32'd6, 32'd7);
    apply_comb(ALU_ADD, 32'd1, 32'd1, 32'd2);
    do_mul(32'hFFFF_FFFF, 32'd2);
    do_mul(32'd3, 32'd3);
    do_mul(32'd3, 32'd1);
    do_mul(32'd3, 32'h8000_0000);
    do_mul(32'h1234_5678, 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.Valid = 1'b1; bus.ALUControl = ALU_MUL; bus.SrcA = 32'd9; bus.SrcB = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.Valid = 1'b0;
    end
    #2;
    check("pre_reset_stall", bus.Stall, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_busy_stall", bus.Stall, 1'b0);
    check("rst_busy_muldone", bus.MulDone, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("post_rst_muldone", bus.MulDone, 1'b0);
      check("post_rst_stall", bus.Stall, 1'b0);
    end
    do_mul(32'd4, 32'd5);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 2) ? 32'($urandom_range(0, 255)) : $urandom;
      do_mul(a, b);
    end
    apply_comb(ALU_SUB, 32'd10, 32'd3, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
